lsu_data_mem: RTL

Parametrised RV32 data memory with a valid/ready request-response interface, the next generation of the core's single-cycle data RAM. It performs byte/half/word loads and stores at any aligned byte offset within a word, with lane-shifted writes and correct sign/zero extension on loads. It adds configurable read latency, misalignment and range error reporting, and response back-pressure. It sits between the load/store stage of the pipelined core and on-chip RAM.

---
 rtl/lsu_data_mem_if.sv | 27 ++
 rtl/lsu_data_mem.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lsu_data_mem_if.sv
// Request/response bundle between the load/store stage and the data memory.
// Latency: none; wires only.
// Backpressure: req_ready stalls the requester, rsp_ready stalls the memory.
// Ports: req_* carry one load/store (valid/ready), rsp_* return its result (valid/ready).
interface lsu_data_mem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/lsu_data_mem.sv
// RV32 data memory: byte/half/word loads and stores with range and alignment errors.
// Latency: response visible READ_LAT cycles after accept; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
// Ports: clk, rst (sync, active-high), bus (slave side of lsu_data_mem_if).
module lsu_data_mem #(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   lsu_data_mem_if.slave bus
);
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
   // Counter preload so that WAIT lasts exactly READ_LAT-1 cycles.
   localparam logic [1:0]  WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] data_q;
   logic        err_q;

   logic [31:0] mem [DEPTH] = '{default: '0};

   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             in_range, bad, accept;
   logic [31:0]      rd_word, load_val, wdata_sh;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [3:0]       be;

   // Decode: 33-bit compare keeps addresses past the top from wrapping back in.
   assign offset   = bus.req_addr - BASE_ADDR;
   assign idx      = offset[IDX_W+1:2];
   assign lane     = offset[1:0];
   assign in_range = (bus.req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
   assign bad      = !in_range || (bus.req_size == 2'b11)
                   || ((bus.req_size == 2'b01) && lane[0])
                   || ((bus.req_size == 2'b10) && (lane != 2'b00));
   assign accept   = bus.req_valid && bus.req_ready;

   assign rd_word  = mem[idx];
   assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
   assign rd_half  = rd_word[{lane[1], 4'b0000} +: 16];
   assign wdata_sh = bus.req_wdata << {lane, 3'b000};

   always_comb begin
      load_val = '0;
      be       = 4'b0000;
      case (bus.req_size)
         2'b00: begin
            load_val = {{24{!bus.req_unsigned && rd_byte[7]}}, rd_byte};
            be       = 4'b0001 << lane;
         end
         2'b01: begin
            load_val = {{16{!bus.req_unsigned && rd_half[15]}}, rd_half};
            be       = 4'b0011 << lane;
         end
         default: begin
            load_val = rd_word;
            be       = 4'b1111;
         end
      endcase
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = !rst;
            if (accept) begin
               if (READ_LAT <= 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Data only leaves the block while the response is presented.
   assign bus.rsp_rdata = bus.rsp_valid ? data_q : 32'h0;
   assign bus.rsp_err   = bus.rsp_valid && err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            data_q <= (bad || bus.req_we) ? 32'h0 : load_val;
            err_q  <= bad;
         end
      end
   end

   // Array is not reset; accept already excludes reset cycles.
   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end
endmodule
